// File: rtl/alu_pkg.sv
// Shared encodings for the ADD/AND/CMP execute slice: opcodes, condition codes, NZCV bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } alu_op_e;

  localparam logic [3:0] COND_AL = 4'b0000;
  localparam logic [3:0] COND_EQ = 4'b0001;
  localparam logic [3:0] COND_GT = 4'b0010;
  localparam logic [3:0] COND_LT = 4'b0011;
  localparam logic [3:0] COND_GE = 4'b0100;
  localparam logic [3:0] COND_LE = 4'b0101;
  localparam logic [3:0] COND_HI = 4'b0110;
  localparam logic [3:0] COND_CC = 4'b0111;
  localparam logic [3:0] COND_CS = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational condition evaluator: decides whether an instruction with code cond may execute
// given the current NZCV flags. Codes above CS never pass.
module alu_cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_GT: pass = ~z & (n == v);
      COND_LT: pass = (n != v);
      COND_GE: pass = (n == v);
      COND_LE: pass = z | (n != v);
      COND_HI: pass = c & ~z;
      COND_CC: pass = ~c;
      COND_CS: pass = c;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_add_and_cmp.sv
// Registered ADD/AND/CMP execute slice owning the NZCV register; 1-cycle latency.
// Condition gating is built only when ALU_COND_EN is defined; otherwise every legal op executes.
module alu_add_and_cmp
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [3:0]       cond,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             executed,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic             cond_pass;
  logic             op_legal;
  logic             do_exec;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] and_res;
  logic             add_v;
  logic             cmp_v;
  logic [WIDTH-1:0] result_next;
  logic [3:0]       flags_next;

`ifdef ALU_COND_EN
  alu_cond_check u_cond_check (
    .cond (cond),
    .nzcv (flags),
    .pass (cond_pass)
  );
`else
  logic cond_unused;
  assign cond_unused = ^cond;
  assign cond_pass   = 1'b1;
`endif

  assign op_legal = (op != OP_RSV);
  assign do_exec  = in_valid & cond_pass & op_legal;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign sum      = sum_ext[MSB:0];
  assign diff     = diff_ext[MSB:0];
  assign and_res  = a & b;

  // Signed overflow: ADD overflows when like-signed operands give an unlike-signed sum;
  // CMP when unlike-signed operands give a difference whose sign differs from a.
  assign add_v = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
  assign cmp_v = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);

  always_comb begin
    result_next = result;
    flags_next  = flags;
    case (alu_op_e'(op))
      OP_ADD: begin
        result_next = sum;
        if (s) begin
          flags_next[FLAG_N] = sum[MSB];
          flags_next[FLAG_Z] = (sum == '0);
          flags_next[FLAG_C] = sum_ext[WIDTH];
          flags_next[FLAG_V] = add_v;
        end
      end
      OP_AND: begin
        result_next = and_res;
        if (s) begin
          flags_next[FLAG_N] = and_res[MSB];
          flags_next[FLAG_Z] = (and_res == '0);
        end
      end
      OP_CMP: begin
        flags_next[FLAG_N] = diff[MSB];
        flags_next[FLAG_Z] = (a == b);
        // The extension bit is the borrow; carry means no borrow (a >= b unsigned).
        flags_next[FLAG_C] = ~diff_ext[WIDTH];
        flags_next[FLAG_V] = cmp_v;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      executed  <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
    end else begin
      out_valid <= in_valid;
      executed  <= do_exec;
      if (do_exec) begin
        result <= result_next;
        flags  <= flags_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_add_and_cmp.sv
// Self-checking bench for alu_add_and_cmp: directed cases followed by random issue checked
// against an arithmetic reference model of the ADD/AND/CMP and flag rules.
module tb_alu_add_and_cmp;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [3:0]  cond;
  logic        s;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        executed;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int fails  = 0;

  logic        m_valid;
  logic        m_exec;
  logic [31:0] m_result;
  logic [3:0]  m_flags;

  alu_add_and_cmp #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .cond      (cond),
    .s         (s),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .executed  (executed),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
`ifdef ALU_COND_EN
    case (c)
      4'd0: return 1;
      4'd1: return z;
      4'd2: return !z && (n == v);
      4'd3: return n != v;
      4'd4: return n == v;
      4'd5: return z || (n != v);
      4'd6: return cy && !z;
      4'd7: return !cy;
      4'd8: return cy;
      default: return 0;
    endcase
`else
    return 1;
`endif
  endfunction

  // Reference: plain 64-bit integer arithmetic, overflow judged by range of the true signed result.
  task automatic model_step(input logic rn, input logic v, input logic [1:0] o, input logic [3:0] c,
                            input logic sf, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy, usum;
    longint sx, sy, sres;
    logic [31:0] r;
    bit ovf;
    if (!rn) begin
      m_valid = 0; m_exec = 0; m_result = 0; m_flags = 0;
      return;
    end
    m_valid = v;
    m_exec  = 0;
    if (!v) return;
    if (o == 2'b11 || !model_pass(c, m_flags)) return;
    m_exec = 1;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (o == 2'b00) begin
      usum = ux + uy;
      r = usum[31:0];
      sres = sx + sy;
      ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      m_result = r;
      if (sf) m_flags = {r[31], r == 0, usum >= 64'h1_0000_0000, ovf};
    end else if (o == 2'b01) begin
      r = x & y;
      m_result = r;
      if (sf) m_flags = {r[31], r == 0, m_flags[1], m_flags[0]};
    end else begin
      sres = sx - sy;
      r = x - y;
      ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      m_flags = {r[31], x == y, ux >= uy, ovf};
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic [1:0] o, input logic [3:0] c,
                      input logic sf, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    rst_n = rn; in_valid = v; op = o; cond = c; s = sf; a = x; b = y;
    @(posedge clk);
    #1;
    model_step(rn, v, o, c, sf, x, y);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("executed", 32'(executed), 32'(m_exec));
    check("result", result, m_result);
    check("flags", 32'(flags), 32'(m_flags));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; op = 0; cond = 0; s = 0; a = 0; b = 0;
    m_valid = 0; m_exec = 0; m_result = 0; m_flags = 0;

    step(0, 0, 2'b00, 4'h0, 0, 0, 0);
    step(0, 0, 2'b00, 4'h0, 0, 0, 0);
    check("reset_flags", 32'(flags), 32'h0);

    step(1, 1, 2'b00, 4'h0, 1, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flags", 32'(flags), 32'b1001);

    step(1, 1, 2'b00, 4'h0, 1, 32'hFFFF_FFFF, 32'h1);
    check("add_carry_flags", 32'(flags), 32'b0110);
    step(1, 1, 2'b00, 4'h0, 1, 32'h7FFF_FFFF, 32'h1);
    step(1, 1, 2'b00, 4'h0, 0, 32'hFFFF_FFFF, 32'h1);
    check("add_nos_result", result, 32'h0);
    check("add_nos_flags", 32'(flags), 32'b1001);

    step(1, 1, 2'b10, 4'h0, 0, 32'd5, 32'd5);
    check("cmp_eq_flags", 32'(flags), 32'b0110);
    check("cmp_keeps_result", result, 32'h0);
    step(1, 1, 2'b10, 4'h0, 0, 32'd3, 32'd5);
    check("cmp_lt_flags", 32'(flags), 32'b1000);

    step(1, 1, 2'b10, 4'h0, 0, 32'd5, 32'd5);
    step(1, 1, 2'b00, 4'h1, 0, 32'd2, 32'd3);
    check("eq_add_result", result, 32'd5);
    step(1, 1, 2'b00, 4'h3, 0, 32'd1, 32'd1);
    step(1, 1, 2'b00, 4'hF, 0, 32'd7, 32'd7);

    step(1, 1, 2'b10, 4'h0, 0, 32'd5, 32'd5);
    step(1, 1, 2'b01, 4'h0, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    check("and_result", result, 32'h0);
    check("and_flags", 32'(flags), 32'b0110);
    step(1, 1, 2'b11, 4'h0, 1, 32'h1234_5678, 32'h1);
    check("rsv_not_exec", 32'(executed), 32'h0);

    step(1, 0, 2'b00, 4'h0, 1, 32'h1, 32'h1);
    step(0, 1, 2'b00, 4'h0, 1, 32'h1, 32'h1);
    check("rst_issue_result", result, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) != 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           pick_operand(), pick_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
